// File: rtl/spi_word_receiver.sv
// SPI mode-0 target: one full-duplex word per cs-low frame, p_nbits wide.
// Latency: push_en/frame_err appear 3 clk after cs pin rises; pull_en 3 clk after cs pin falls.
// Backpressure: none, so every push_en strobe must be taken by the consumer.
//
// Ports:
//   clk, rst          system clock, synchronous active-low reset
//   cs, sclk, mosi    SPI pins from the host, asynchronous to clk
//   miso              SPI data to the host, 0 outside a frame
//   push_msg/push_en  last complete received word, with a one-cycle valid strobe
//   pull_msg/pull_en  word for the next frame, sampled on the pull_en cycle
//   frame_err         one-cycle strobe when a frame ends with the wrong bit count
module spi_word_receiver #(
   parameter int p_nbits = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cs,
   input  logic               sclk,
   input  logic               mosi,
   output logic               miso,
   output logic [p_nbits-1:0] push_msg,
   output logic               push_en,
   input  logic [p_nbits-1:0] pull_msg,
   output logic               pull_en,
   output logic               frame_err
);

   localparam int CW = $clog2(p_nbits + 2);
   localparam logic [CW-1:0] NBITS     = CW'(p_nbits);
   localparam logic [CW-1:0] NBITS_SAT = CW'(p_nbits + 1);

   localparam logic [1:0] LOCKOUT = 2'd0;
   localparam logic [1:0] IDLE    = 2'd1;
   localparam logic [1:0] ACTIVE  = 2'd2;

   logic [1:0]         state;
   logic               cs_s1, cs_s2, cs_h;
   logic               sclk_s1, sclk_s2, sclk_h;
   logic               mosi_s1, mosi_s2;
   logic [1:0]         fill;
   logic [p_nbits-1:0] rx;
   logic [p_nbits-1:0] tx;
   logic [CW-1:0]      cnt;

   logic cs_fall, cs_rise, sclk_rise, sclk_fall;

   assign cs_fall   =  cs_h   & ~cs_s2;
   assign cs_rise   = ~cs_h   &  cs_s2;
   assign sclk_rise = ~sclk_h &  sclk_s2;
   assign sclk_fall =  sclk_h & ~sclk_s2;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= LOCKOUT;
         cs_s1     <= 1'b1;
         cs_s2     <= 1'b1;
         cs_h      <= 1'b1;
         sclk_s1   <= 1'b0;
         sclk_s2   <= 1'b0;
         sclk_h    <= 1'b0;
         mosi_s1   <= 1'b0;
         mosi_s2   <= 1'b0;
         fill      <= 2'b00;
         rx        <= '0;
         tx        <= '0;
         cnt       <= '0;
         miso      <= 1'b0;
         push_msg  <= '0;
         push_en   <= 1'b0;
         pull_en   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         cs_s1   <= cs;
         cs_s2   <= cs_s1;
         cs_h    <= cs_s2;
         sclk_s1 <= sclk;
         sclk_s2 <= sclk_s1;
         sclk_h  <= sclk_s2;
         mosi_s1 <= mosi;
         mosi_s2 <= mosi_s1;
         // The cs synchronizer holds its reset value (high) for two cycles after
         // release; fill marks when cs_s2 reflects the real pin, so a frame that
         // is already under way at release cannot be mistaken for an idle bus.
         fill    <= {fill[0], 1'b1};

         push_en   <= 1'b0;
         pull_en   <= 1'b0;
         frame_err <= 1'b0;

         case (state)
            LOCKOUT: begin
               miso <= 1'b0;
               if (fill[1] && cs_s2) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               miso <= 1'b0;
               if (cs_fall) begin
                  state   <= ACTIVE;
                  tx      <= pull_msg;
                  pull_en <= 1'b1;
                  cnt     <= '0;
                  miso    <= pull_msg[p_nbits-1];
               end
            end
            ACTIVE: begin
               // cs edge wins over an sclk edge seen in the same cycle.
               if (cs_rise) begin
                  state <= IDLE;
                  miso  <= 1'b0;
                  if (cnt == NBITS) begin
                     push_msg <= rx;
                     push_en  <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else if (sclk_rise) begin
                  rx <= {rx[p_nbits-2:0], mosi_s2};
                  if (cnt != NBITS_SAT) begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (sclk_fall) begin
                  tx   <= {tx[p_nbits-2:0], 1'b0};
                  miso <= tx[p_nbits-2];
               end
            end
            default: begin
               state <= LOCKOUT;
               miso  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_word_receiver.sv
// Bench for spi_word_receiver: a host model drives SPI frames and collects miso,
// a monitor gathers push/pull/frame_err strobes, and a frame-level reference
// predicts the pushed words, error strobes and transmitted words.
module tb_spi_word_receiver;

   logic        clk;
   logic        rst;
   logic        cs;
   logic        sclk;
   logic        mosi;
   logic        miso;
   logic [31:0] push_msg;
   logic        push_en;
   logic [31:0] pull_msg;
   logic        pull_en;
   logic        frame_err;

   spi_word_receiver #(.p_nbits(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .cs        (cs),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .push_msg  (push_msg),
      .push_en   (push_en),
      .pull_msg  (pull_msg),
      .pull_en   (pull_en),
      .frame_err (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Observed strobes.
   logic [31:0] got_push_q[$];
   int          got_ferr = 0;
   int          got_pull = 0;
   int          overlap  = 0;

   // Reference model state.
   logic [31:0] exp_push_q[$];
   int          exp_ferr  = 0;
   int          exp_pull  = 0;
   logic [31:0] last_push = 32'h0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (push_en) got_push_q.push_back(push_msg);
      if (frame_err) got_ferr++;
      if (pull_en) got_pull++;
      if ((int'(push_en) + int'(pull_en) + int'(frame_err)) > 1) overlap++;
   end

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Bits the host should see on miso: the word loaded at cs fall, MSB first,
   // zeros once its bits run out.
   function automatic logic [63:0] exp_miso(input logic [31:0] p, input int n);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < n; i++) r = {r[62:0], (i < 32) ? p[31-i] : 1'b0};
      return r;
   endfunction

   // One host frame. abort_at >= 0 pulses reset before that bit with cs held low;
   // extra raises sclk together with cs at the end of the frame.
   task automatic frame(input logic [63:0] word, input int nbits, input int ph,
                        input int gap, input bit scramble, input bit extra,
                        input int abort_at, output logic [63:0] got_miso);
      got_miso = '0;
      cs = 1'b0;
      wait_clk(ph);
      for (int i = 0; i < nbits; i++) begin
         if (i == abort_at) begin
            rst = 1'b0;
            wait_clk(1);
            chk("rst_push_en", {63'd0, push_en}, 64'd0);
            chk("rst_frame_err", {63'd0, frame_err}, 64'd0);
            chk("rst_miso", {63'd0, miso}, 64'd0);
            chk("rst_push_msg", {32'd0, push_msg}, 64'd0);
            wait_clk(1);
            rst = 1'b1;
         end
         mosi = word[nbits-1-i];
         wait_clk(ph);
         got_miso = {got_miso[62:0], miso};
         sclk = 1'b1;
         if (scramble && i == 8) pull_msg = $urandom;
         wait_clk(ph);
         sclk = 1'b0;
      end
      wait_clk(ph);
      if (extra) begin
         mosi = 1'b1;
         sclk = 1'b1;
      end
      cs = 1'b1;
      wait_clk(gap);
      sclk = 1'b0;
   endtask

   task automatic run(input logic [63:0] word, input int nbits, input int ph, input int gap,
                      input bit scramble, input bit extra, input int abort_at,
                      input logic [31:0] pull);
      logic [63:0] m;
      pull_msg = pull;
      frame(word, nbits, ph, gap, scramble, extra, abort_at, m);
      exp_pull++;
      if (abort_at >= 0) begin
         last_push = 32'h0;
      end else begin
         chk("miso_word", m, exp_miso(pull, nbits));
         if (nbits == 32) begin
            exp_push_q.push_back(word[31:0]);
            last_push = word[31:0];
         end else begin
            exp_ferr++;
         end
      end
   endtask

   task automatic settle(input string tag);
      logic [31:0] g;
      logic [31:0] e;
      wait_clk(8);
      chk({tag, "_push_cnt"}, 64'(got_push_q.size()), 64'(exp_push_q.size()));
      while (got_push_q.size() > 0 && exp_push_q.size() > 0) begin
         g = got_push_q.pop_front();
         e = exp_push_q.pop_front();
         chk({tag, "_push_val"}, {32'd0, g}, {32'd0, e});
      end
      got_push_q.delete();
      exp_push_q.delete();
      chk({tag, "_ferr_cnt"}, 64'(got_ferr), 64'(exp_ferr));
      chk({tag, "_pull_cnt"}, 64'(got_pull), 64'(exp_pull));
      chk({tag, "_push_hold"}, {32'd0, push_msg}, {32'd0, last_push});
      chk({tag, "_miso_idle"}, {63'd0, miso}, 64'd0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", n_chk, n_bad);
      $fatal(1);
   end

   initial begin
      logic [63:0] w;
      int nb;
      int sel;
      rst = 1'b0;
      cs = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      pull_msg = 32'h0;
      wait_clk(3);
      chk("reset_push_en", {63'd0, push_en}, 64'd0);
      chk("reset_pull_en", {63'd0, pull_en}, 64'd0);
      chk("reset_frame_err", {63'd0, frame_err}, 64'd0);
      chk("reset_miso", {63'd0, miso}, 64'd0);
      chk("reset_push_msg", {32'd0, push_msg}, 64'd0);
      rst = 1'b1;
      wait_clk(6);
      chk("post_reset_push_en", {63'd0, push_en}, 64'd0);

      // Basic word, with pull_msg disturbed mid-frame.
      run(64'hDEADBEEF, 32, 5, 6, 1'b1, 1'b0, -1, 32'hA5A50F0F);
      settle("deadbeef");

      // Short and long frames.
      run({$urandom, $urandom}, 31, 5, 6, 1'b0, 1'b0, -1, $urandom);
      run({$urandom, $urandom}, 33, 5, 6, 1'b0, 1'b0, -1, $urandom);
      settle("badlen");

      // Back-to-back with the minimum cs gap.
      run(64'h00000004, 32, 4, 4, 1'b0, 1'b0, -1, $urandom);
      run(64'h12345678, 32, 4, 4, 1'b0, 1'b0, -1, $urandom);
      settle("b2b");

      // Reset in mid-frame, then a clean frame.
      run({$urandom, $urandom}, 32, 5, 6, 1'b0, 1'b0, 16, $urandom);
      run(64'h00000001, 32, 5, 6, 1'b0, 1'b0, -1, $urandom);
      settle("abort");

      // sclk rising together with cs rising.
      run({32'd0, $urandom}, 32, 5, 6, 1'b0, 1'b1, -1, $urandom);
      settle("coincide");

      // Randomized frames.
      for (int k = 0; k < 30; k++) begin
         sel = $urandom_range(0, 4);
         nb = (sel == 0) ? 31 : (sel == 4) ? 33 : 32;
         w = {$urandom, $urandom};
         run(w, nb, $urandom_range(4, 7), $urandom_range(4, 8),
             1'($urandom_range(0, 1)), 1'b0, -1, $urandom);
      end
      settle("random");

      chk("strobe_overlap", 64'(overlap), 64'd0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
